// File: rtl/control_unit_pkg.sv
// Shared types and constants for the control unit: FSM states, instruction classes,
// ALU function codes and datapath mux selects.
package control_unit_pkg;

    typedef enum logic [4:0] {
        StReset, StInit, StF1, StF2, StF3, StDec, StExec,
        StLa, StLw, StLr, StSd, StSw, StCr, StCt, StBt, StPcu, StPcj
    } state_t;

    typedef enum logic [3:0] {
        ClsNone, ClsAlu, ClsPsr, ClsWim, ClsTbr, ClsLd, ClsSt, ClsCall, ClsBranch
    } instr_cls_t;

    localparam logic [5:0] AluAdd   = 6'b000000;
    localparam logic [5:0] AluPassA = 6'b111110;
    localparam logic [5:0] AluPassB = 6'b111111;

    localparam logic [1:0] MuxAPc    = 2'b01;
    localparam logic [1:0] MuxAMdr   = 2'b11;
    localparam logic [1:0] MuxBRf    = 2'b00;
    localparam logic [1:0] MuxBSimm  = 2'b01;
    localparam logic [1:0] MuxBDisp  = 2'b11;
    localparam logic [1:0] MuxOpIr   = 2'b00;
    localparam logic [1:0] MuxOpOut  = 2'b01;
    localparam logic [1:0] RfbRd     = 2'b01;
    localparam logic [1:0] DestR15   = 2'b01;
    localparam logic [1:0] NpcAdd4   = 2'b00;
    localparam logic [1:0] NpcAlu    = 2'b01;
    localparam logic [1:0] NpcConst4 = 2'b11;
    localparam logic [1:0] PcNpc     = 2'b00;
    localparam logic [1:0] PcConst0  = 2'b11;
    localparam logic [1:0] MdrMem    = 2'b00;
    localparam logic [1:0] MdrAlu    = 2'b01;

    localparam logic [5:0] Op3Ld    = 6'b000000;
    localparam logic [5:0] Op3St    = 6'b000100;
    localparam logic [5:0] Op3WrPsr = 6'b110001;
    localparam logic [5:0] Op3WrWim = 6'b110010;
    localparam logic [5:0] Op3WrTbr = 6'b110011;
    localparam logic [2:0] Op2Bicc  = 3'b010;

endpackage

// File: rtl/cu_decoder.sv
// Classifies the current instruction from its op and op3/op2 fields so the FSM
// can dispatch from DEC.
module cu_decoder
    import control_unit_pkg::*;
(
    input  logic [1:0] op,
    input  logic [5:0] op3,
    output instr_cls_t cls
);

    always_comb begin
        cls = ClsNone;
        unique case (op)
            2'b00: cls = (op3[5:3] == Op2Bicc) ? ClsBranch : ClsNone;
            2'b01: cls = ClsCall;
            2'b10: begin
                if (op3[5:4] != 2'b11) begin
                    cls = ClsAlu;
                end else begin
                    case (op3)
                        Op3WrPsr: cls = ClsPsr;
                        Op3WrWim: cls = ClsWim;
                        Op3WrTbr: cls = ClsTbr;
                        default:  cls = ClsNone;
                    endcase
                end
            end
            2'b11: begin
                case (op3)
                    Op3Ld:   cls = ClsLd;
                    Op3St:   cls = ClsSt;
                    default: cls = ClsNone;
                endcase
            end
            default: cls = ClsNone;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Microsequencer for a SPARC-style datapath: registered state, outputs decoded
// combinationally from the state and the current instruction.
module control_unit
    import control_unit_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] IR,
    input  logic        Memory_Operation_Complete,
    input  logic        Cond,
    input  logic [1:0]  test,
    output logic        RF_Ld,
    output logic        FR_Ld,
    output logic        IR_Ld,
    output logic        MAR_Ld,
    output logic        MDR_Ld,
    output logic        PSR_Ld,
    output logic        nPC_Ld,
    output logic        PC_Ld,
    output logic        TBR_Ld,
    output logic        WIM_Ld,
    output logic [1:0]  MUX_A,
    output logic [1:0]  MUX_B,
    output logic [1:0]  MUX_OP,
    output logic [1:0]  MUX_RFA,
    output logic [1:0]  MUX_RFB,
    output logic [1:0]  MUX_RFDest,
    output logic [1:0]  MUX_nPC,
    output logic [1:0]  MUX_PC,
    output logic        MUX_Add4,
    output logic [1:0]  MUX_MDR,
    output logic        RW,
    output logic        MOV,
    output logic [5:0]  OP,
    output logic        C_In
);

    state_t     state_q, state_d;
    instr_cls_t cls;
    logic [1:0] b_sel;
    logic       unused_bits;

    // test is a reserved debug input; the remaining IR fields belong to the datapath.
    assign unused_bits = ^{test, IR[29:25], IR[18:14], IR[12:0]};

    assign b_sel = IR[13] ? MuxBSimm : MuxBRf;

    cu_decoder u_decoder (
        .op  (IR[31:30]),
        .op3 (IR[24:19]),
        .cls (cls)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= StReset;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StReset: state_d = StInit;
            StInit:  state_d = StF1;
            StF1:    state_d = StF2;
            StF2:    state_d = Memory_Operation_Complete ? StF3 : StF2;
            StF3:    state_d = StDec;
            StDec: begin
                case (cls)
                    ClsAlu, ClsPsr, ClsWim, ClsTbr: state_d = StExec;
                    ClsLd, ClsSt:                   state_d = StLa;
                    ClsCall:                        state_d = StCr;
                    ClsBranch:                      state_d = StBt;
                    default:                        state_d = StPcu;
                endcase
            end
            StExec:  state_d = StPcu;
            StLa:    state_d = (cls == ClsSt) ? StSd : StLw;
            StLw:    state_d = Memory_Operation_Complete ? StLr : StLw;
            StLr:    state_d = StPcu;
            StSd:    state_d = StSw;
            StSw:    state_d = Memory_Operation_Complete ? StPcu : StSw;
            StCr:    state_d = StCt;
            StCt:    state_d = StPcj;
            StBt:    state_d = Cond ? StPcj : StPcu;
            StPcu:   state_d = StF1;
            StPcj:   state_d = StF1;
            default: state_d = StReset;
        endcase
    end

    always_comb begin
        RF_Ld      = 1'b0;
        FR_Ld      = 1'b0;
        IR_Ld      = 1'b0;
        MAR_Ld     = 1'b0;
        MDR_Ld     = 1'b0;
        PSR_Ld     = 1'b0;
        nPC_Ld     = 1'b0;
        PC_Ld      = 1'b0;
        TBR_Ld     = 1'b0;
        WIM_Ld     = 1'b0;
        MUX_A      = 2'b00;
        MUX_B      = 2'b00;
        MUX_OP     = 2'b00;
        MUX_RFA    = 2'b00;
        MUX_RFB    = 2'b00;
        MUX_RFDest = 2'b00;
        MUX_nPC    = 2'b00;
        MUX_PC     = 2'b00;
        MUX_Add4   = 1'b0;
        MUX_MDR    = 2'b00;
        RW         = 1'b1;
        MOV        = 1'b0;
        OP         = AluAdd;
        C_In       = 1'b0;
        unique case (state_q)
            StInit: begin
                PC_Ld   = 1'b1;
                nPC_Ld  = 1'b1;
                MUX_PC  = PcConst0;
                MUX_nPC = NpcConst4;
            end
            StF1: begin
                MAR_Ld = 1'b1;
                MUX_A  = MuxAPc;
                MUX_OP = MuxOpOut;
                OP     = AluPassA;
            end
            StF2, StLw: begin
                MOV     = 1'b1;
                MDR_Ld  = 1'b1;
                MUX_MDR = MdrMem;
            end
            StF3: IR_Ld = 1'b1;
            StExec: begin
                MUX_B = b_sel;
                case (cls)
                    ClsPsr, ClsWim, ClsTbr: begin
                        PSR_Ld = (cls == ClsPsr);
                        WIM_Ld = (cls == ClsWim);
                        TBR_Ld = (cls == ClsTbr);
                        MUX_OP = MuxOpOut;
                        OP     = AluAdd;
                    end
                    default: begin
                        RF_Ld  = 1'b1;
                        FR_Ld  = IR[23];
                        MUX_OP = MuxOpIr;
                    end
                endcase
            end
            StLa: begin
                MAR_Ld = 1'b1;
                MUX_B  = b_sel;
                MUX_OP = MuxOpOut;
                OP     = AluAdd;
            end
            StLr: begin
                RF_Ld  = 1'b1;
                MUX_A  = MuxAMdr;
                MUX_OP = MuxOpOut;
                OP     = AluPassA;
            end
            StSd: begin
                MDR_Ld  = 1'b1;
                MUX_RFB = RfbRd;
                MUX_MDR = MdrAlu;
                MUX_OP  = MuxOpOut;
                OP      = AluPassB;
            end
            StSw: begin
                MOV = 1'b1;
                RW  = 1'b0;
            end
            StCr: begin
                RF_Ld      = 1'b1;
                MUX_RFDest = DestR15;
                MUX_A      = MuxAPc;
                MUX_OP     = MuxOpOut;
                OP         = AluPassA;
            end
            StCt, StBt: begin
                // A not-taken branch passes through BT without touching nPC.
                if (state_q == StCt || Cond) begin
                    nPC_Ld  = 1'b1;
                    MUX_nPC = NpcAlu;
                    MUX_A   = MuxAPc;
                    MUX_B   = MuxBDisp;
                    MUX_OP  = MuxOpOut;
                    OP      = AluAdd;
                end
            end
            StPcu: begin
                PC_Ld    = 1'b1;
                MUX_PC   = PcNpc;
                nPC_Ld   = 1'b1;
                MUX_nPC  = NpcAdd4;
                MUX_Add4 = 1'b1;
            end
            StPcj: begin
                PC_Ld  = 1'b1;
                MUX_PC = PcNpc;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-cycle expected output vectors are queued
// as stimulus is driven and compared mid-cycle.
module tb_control_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] IR;
    logic        Memory_Operation_Complete;
    logic        Cond;
    logic [1:0]  test;
    logic        RF_Ld, FR_Ld, IR_Ld, MAR_Ld, MDR_Ld, PSR_Ld, nPC_Ld, PC_Ld, TBR_Ld, WIM_Ld;
    logic [1:0]  MUX_A, MUX_B, MUX_OP, MUX_RFA, MUX_RFB, MUX_RFDest, MUX_nPC, MUX_PC, MUX_MDR;
    logic        MUX_Add4, RW, MOV, C_In;
    logic [5:0]  OP;

    control_unit dut (
        .Clk                       (Clk),
        .Reset                     (Reset),
        .IR                        (IR),
        .Memory_Operation_Complete (Memory_Operation_Complete),
        .Cond                      (Cond),
        .test                      (test),
        .RF_Ld                     (RF_Ld),
        .FR_Ld                     (FR_Ld),
        .IR_Ld                     (IR_Ld),
        .MAR_Ld                    (MAR_Ld),
        .MDR_Ld                    (MDR_Ld),
        .PSR_Ld                    (PSR_Ld),
        .nPC_Ld                    (nPC_Ld),
        .PC_Ld                     (PC_Ld),
        .TBR_Ld                    (TBR_Ld),
        .WIM_Ld                    (WIM_Ld),
        .MUX_A                     (MUX_A),
        .MUX_B                     (MUX_B),
        .MUX_OP                    (MUX_OP),
        .MUX_RFA                   (MUX_RFA),
        .MUX_RFB                   (MUX_RFB),
        .MUX_RFDest                (MUX_RFDest),
        .MUX_nPC                   (MUX_nPC),
        .MUX_PC                    (MUX_PC),
        .MUX_Add4                  (MUX_Add4),
        .MUX_MDR                   (MUX_MDR),
        .RW                        (RW),
        .MOV                       (MOV),
        .OP                        (OP),
        .C_In                      (C_In)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       rf, fr, ir, mar, mdr, psr, npc, pc, tbr, wim;
        logic [1:0] a, b, op_sel, rfa, rfb, rfdest, npc_sel, pc_sel;
        logic       add4;
        logic [1:0] mdr_sel;
        logic       rw, mov;
        logic [5:0] alu;
        logic       cin;
    } outs_t;

    typedef struct {
        string tag;
        outs_t val;
    } sb_t;

    typedef enum {
        XIdle, XInit, XF1, XF2, XF3, XExec, XLa, XLw, XLr, XSd, XSw, XCr, XCt, XBt, XPcu, XPcj
    } xst_t;

    outs_t obs;
    sb_t   sb_q[$];
    sb_t   cur;
    int    n_checks = 0;
    int    n_fail = 0;

    assign obs = {RF_Ld, FR_Ld, IR_Ld, MAR_Ld, MDR_Ld, PSR_Ld, nPC_Ld, PC_Ld, TBR_Ld, WIM_Ld,
                  MUX_A, MUX_B, MUX_OP, MUX_RFA, MUX_RFB, MUX_RFDest, MUX_nPC, MUX_PC,
                  MUX_Add4, MUX_MDR, RW, MOV, OP, C_In};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Expected outputs for each control step, taken from the behavioural description.
    function automatic outs_t model(input xst_t s, input logic [31:0] ir, input logic cond);
        outs_t o;
        logic [5:0] op3;
        o = '0;
        o.rw = 1'b1;
        op3 = ir[24:19];
        case (s)
            XInit: begin o.pc = 1; o.npc = 1; o.pc_sel = 2'b11; o.npc_sel = 2'b11; end
            XF1:   begin o.mar = 1; o.a = 2'b01; o.op_sel = 2'b01; o.alu = 6'b111110; end
            XF2, XLw: begin o.mov = 1; o.mdr = 1; end
            XF3:   o.ir = 1;
            XExec: begin
                o.b = ir[13] ? 2'b01 : 2'b00;
                if (op3[5:4] == 2'b11) begin
                    o.op_sel = 2'b01;
                    o.psr = (op3 == 6'b110001);
                    o.wim = (op3 == 6'b110010);
                    o.tbr = (op3 == 6'b110011);
                end else begin
                    o.rf = 1;
                    o.fr = ir[23];
                end
            end
            XLa:   begin o.mar = 1; o.op_sel = 2'b01; o.b = ir[13] ? 2'b01 : 2'b00; end
            XLr:   begin o.rf = 1; o.a = 2'b11; o.op_sel = 2'b01; o.alu = 6'b111110; end
            XSd:   begin
                o.mdr = 1; o.rfb = 2'b01; o.mdr_sel = 2'b01; o.op_sel = 2'b01;
                o.alu = 6'b111111;
            end
            XSw:   begin o.mov = 1; o.rw = 0; end
            XCr:   begin
                o.rf = 1; o.rfdest = 2'b01; o.a = 2'b01; o.op_sel = 2'b01;
                o.alu = 6'b111110;
            end
            XCt:   begin o.npc = 1; o.npc_sel = 2'b01; o.a = 2'b01; o.b = 2'b11; o.op_sel = 2'b01; end
            XBt:   if (cond) begin
                o.npc = 1; o.npc_sel = 2'b01; o.a = 2'b01; o.b = 2'b11; o.op_sel = 2'b01;
            end
            XPcu:  begin o.pc = 1; o.npc = 1; o.add4 = 1; end
            XPcj:  o.pc = 1;
            default: ;
        endcase
        return o;
    endfunction

    always @(negedge Clk) begin
        if (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            check_eq(cur.tag, 64'(obs), 64'(cur.val));
        end
    end

    task automatic push_exp(input xst_t s, input string tag);
        sb_t e;
        e.tag = tag;
        e.val = model(s, IR, Cond);
        sb_q.push_back(e);
    endtask

    task automatic step(input xst_t s, input string tag);
        test = 2'($urandom);
        push_exp(s, tag);
        @(posedge Clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] ir, input int n_wait);
        step(XF1, "f1");
        Memory_Operation_Complete = 1'b0;
        repeat (n_wait) step(XF2, "f2_wait");
        Memory_Operation_Complete = 1'b1;
        step(XF2, "f2_moc");
        IR = ir;
        step(XF3, "f3");
        step(XIdle, "dec");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b0;
        IR = 32'h0;
        Memory_Operation_Complete = 1'b1;
        Cond = 1'b0;
        test = 2'b00;
        repeat (2) @(posedge Clk);
        #1;
        step(XIdle, "reset_hold");
        Reset = 1'b1;
        step(XIdle, "reset_idle");
        step(XInit, "init");

        fetch(32'hA20112D0, 2);
        step(XExec, "add_exec");
        step(XPcu, "add_pcu");

        fetch({2'b10, 5'd3, 6'b010000, 5'd1, 1'b1, 13'd5}, 0);
        step(XExec, "addcc_imm_exec");
        step(XPcu, "addcc_imm_pcu");

        fetch(32'hE2049968, 1);
        step(XLa, "ld_la");
        Memory_Operation_Complete = 1'b0;
        repeat (3) step(XLw, "ld_lw_wait");
        Memory_Operation_Complete = 1'b1;
        step(XLw, "ld_lw_moc");
        step(XLr, "ld_lr");
        step(XPcu, "ld_pcu");

        fetch(32'hE2210968, 0);
        step(XLa, "st_la");
        step(XSd, "st_sd");
        Memory_Operation_Complete = 1'b0;
        step(XSw, "st_sw_wait");
        Memory_Operation_Complete = 1'b1;
        step(XSw, "st_sw_moc");
        step(XPcu, "st_pcu");

        fetch(32'h40000010, 0);
        step(XCr, "call_cr");
        step(XCt, "call_ct");
        step(XPcj, "call_pcj");

        fetch(32'h12800005, 0);
        Cond = 1'b1;
        step(XBt, "bicc_taken_bt");
        step(XPcj, "bicc_taken_pcj");

        fetch(32'h12800005, 0);
        Cond = 1'b0;
        step(XBt, "bicc_not_bt");
        step(XPcu, "bicc_not_pcu");

        fetch({2'b10, 5'd0, 6'b110001, 5'd1, 1'b1, 13'd4}, 0);
        step(XExec, "wrpsr_exec");
        step(XPcu, "wrpsr_pcu");

        fetch({2'b10, 5'd0, 6'b110011, 5'd2, 1'b0, 13'd3}, 0);
        step(XExec, "wrtbr_exec");
        step(XPcu, "wrtbr_pcu");

        fetch(32'h03000000, 0);
        step(XPcu, "sethi_unsup_pcu");

        fetch({2'b11, 5'd1, 6'b000001, 5'd2, 1'b0, 13'd0}, 0);
        step(XPcu, "ldub_unsup_pcu");

        step(XF1, "f1_pre_rst");
        Memory_Operation_Complete = 1'b0;
        step(XF2, "f2_pre_rst");
        Reset = 1'b0;
        #1;
        push_exp(XIdle, "rst_mid_f2");
        @(posedge Clk);
        #1;
        Memory_Operation_Complete = 1'b1;
        step(XIdle, "rst_hold_moc");
        Reset = 1'b1;
        step(XIdle, "rst_release");
        step(XInit, "init_again");
        step(XF1, "f1_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The module SHALL have port Clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-002 The module SHALL have port Reset, input, 1 bit, an asynchronous active-low reset.
REQ-003 The module SHALL have inputs IR (32 bits, current instruction), Memory_Operation_Complete (1 bit, MOC from memory) and Cond (1 bit, branch condition true).
REQ-004 The module SHALL have input test (2 bits), a reserved debug input with no functional effect.
REQ-005 The module SHALL have 1-bit load outputs RF_Ld, FR_Ld (flags), IR_Ld, MAR_Ld, MDR_Ld, PSR_Ld, nPC_Ld, PC_Ld, TBR_Ld and WIM_Ld.
REQ-006 The module SHALL have 2-bit select MUX_A: 00 RF portA, 01 PC, 10 nPC, 11 MDR.
REQ-007 The module SHALL have 2-bit select MUX_B: 00 RF portB, 01 sext simm13, 10 const 4, 11 sext disp (disp22 or disp30, each shifted left 2).
REQ-008 The module SHALL have 2-bit select MUX_OP: 00 ALU op = IR[24:19], 01 ALU op = OP output.
REQ-009 The module SHALL have 2-bit selects MUX_RFA (00 rs1, 01 rd, 11 r0), MUX_RFB (00 rs2, 01 rd, 11 r0) and MUX_RFDest (00 rd, 01 r15).
REQ-010 The module SHALL have 2-bit selects MUX_nPC (00 adder+4, 01 ALU, 11 const 4) and MUX_PC (00 nPC, 01 ALU, 11 const 0).
REQ-011 The module SHALL have 1-bit MUX_Add4 (0 PC, 1 nPC feeds the +4 adder) and 2-bit MUX_MDR (00 memory data, 01 ALU).
REQ-012 The module SHALL have 1-bit RW (1 read, 0 write) and MOV (memory operation valid) outputs.
REQ-013 The module SHALL have a 6-bit OP output (ALU code) and a 1-bit C_In output (ALU carry-in).

Function
REQ-014 Outputs SHALL be decoded combinationally from the current state and IR; the next state SHALL be registered.
REQ-015 ALU codes SHALL be ADD=000000, PASSA=111110, PASSB=111111; C_In SHALL always be 0.
REQ-016 Default for every state: all loads 0, MOV 0, RW 1, all muxes 00, OP 000000.
REQ-017 RESET SHALL be idle and go to INIT.
REQ-018 INIT SHALL assert PC_Ld and nPC_Ld with MUX_PC=11 and MUX_nPC=11, then go to F1.
REQ-019 F1 SHALL assert MAR_Ld with MUX_A=01, MUX_OP=01 and OP=PASSA, then go to F2.
REQ-020 F2 SHALL hold MOV=1, RW=1 and MDR_Ld=1 with MUX_MDR=00, staying in F2 while MOC=0 and going to F3 when MOC=1.
REQ-021 F3 SHALL assert IR_Ld, then go to DEC.
REQ-022 DEC SHALL dispatch on IR[31:30] and op3/op2.
REQ-023 For op=10 with op3[5:4]!=11, EXEC SHALL assert RF_Ld with MUX_OP=00, MUX_B=01 if IR[13]=1 else 00, and FR_Ld=IR[23].
REQ-024 For op=10 with op3=110001/110010/110011, EXEC SHALL load PSR/WIM/TBR respectively from ALU ADD.
REQ-025 For ld (op=11, op3=000000): LA SHALL load MAR with rs1+op2 via ADD; LW SHALL wait on MOC as in F2; LR SHALL assert RF_Ld with MUX_A=11 and OP=PASSA.
REQ-026 For st (op=11, op3=000100): LA SHALL be as for ld; SD SHALL load MDR with MUX_RFB=01, MUX_MDR=01 and OP=PASSB; SW SHALL hold MOV=1, RW=0 until MOC.
REQ-027 For call (op=01): CR SHALL write r15 from PC (MUX_RFDest=01, PASSA); CT SHALL load nPC with PC+disp30 (MUX_A=01, MUX_B=11, ADD) and then go to PCJ.
REQ-028 For Bicc (op=00, op2=010) with Cond=1, BT SHALL load nPC with PC+disp22, then go to PCJ; with Cond=0 it SHALL go to PCU.
REQ-029 Unsupported encodings SHALL go straight to PCU.
REQ-030 PCU SHALL assert PC_Ld (MUX_PC=00) and nPC_Ld (MUX_nPC=00, MUX_Add4=1), then go to F1.
REQ-031 PCJ SHALL load PC only, then go to F1.
REQ-032 Memory wait states SHALL wait indefinitely, with MOC sampled on the clock.

Reset
REQ-033 While Reset=0 the state SHALL be RESET and the outputs SHALL be at the defaults of REQ-016, immediately and independent of Clk.
REQ-034 Reset asserted in any state, including during memory waits, SHALL abort that state with no further loads.

Structure
REQ-035 A shared package SHALL hold the state enumeration (5-bit), the ALU codes and the mux-select constants.
REQ-036 The block SHALL use one sub-module, cu_decoder (IR to dispatch class), with the state register and output logic in control_unit.

Verification
REQ-037 Reset low then high with MOC=1: RESET, INIT (PC_Ld=nPC_Ld=1), F1 (MAR_Ld=1), F2, F3 (IR_Ld=1).
REQ-038 IR=0xA20112D0 (add) with MOC=1: DEC, then EXEC with RF_Ld=1, MUX_OP=00, MUX_B=00, FR_Ld=0, then PCU, then F1.
REQ-039 IR=0xE2049968 (ld) with MOC held 0 for 3 cycles: LW holds MOV=1, RW=1; LR asserts RF_Ld=1 with MUX_A=11.
REQ-040 IR=0xE2210968 (st): SD asserts MDR_Ld=1 with MUX_MDR=01; SW drives RW=0, MOV=1; on MOC it goes to PCU.
REQ-041 Bicc with Cond=1: BT asserts nPC_Ld with MUX_B=11, then PCJ; with Cond=0 it goes to PCU.
REQ-042 Reset low mid-F2: all outputs 0, RW=1 within the same cycle.
